// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Brief    : Edge-detecting maskable/NMI interrupt front end for the control
//            unit, with fixed priority (index 0 highest) and service tracking.
// Revision : 1.0
// ============================================================================
module interrupt_controller #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             nmi_i,
    input  logic             mask_we_i,
    input  logic [N_IRQ-1:0] mask_wdata_i,
    input  logic             savePC_i,
    input  logic             INA_i,
    input  logic             eoi_i,
    output logic             interrupt_o,
    output logic             nmint_o,
    output logic             busy_o,
    output logic [ID_W-1:0]  irq_id_o,
    output logic             in_nmi_o,
    output logic             spurious_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MI   = 2'd1,
        S_NMI  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] prev_irq_q;
    logic             prev_nmi_q;
    logic             nmi_pend_q, nmi_pend_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic             spurious_q, spurious_d;

    logic [N_IRQ-1:0] w_enabled;
    logic [N_IRQ-1:0] w_rise;
    logic             w_nmi_rise;
    logic [N_IRQ-1:0] w_first_oh;
    logic [ID_W-1:0]  w_first_id;

    assign w_enabled  = pending_q & mask_q;
    assign w_rise     = irq_i & ~prev_irq_q;
    assign w_nmi_rise = nmi_i & ~prev_nmi_q;

    // Scan from the top so the lowest enabled index is the one left standing.
    always_comb begin : p_prio
        w_first_oh = '0;
        w_first_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_enabled[i]) begin
                w_first_oh    = '0;
                w_first_oh[i] = 1'b1;
                w_first_id    = ID_W'(i);
            end
        end
    end

    always_comb begin : p_next
        state_d    = state_q;
        pending_d  = pending_q;
        nmi_pend_d = nmi_pend_q;
        irq_id_d   = irq_id_q;
        spurious_d = 1'b0;
        mask_d     = mask_we_i ? mask_wdata_i : mask_q;

        case (state_q)
            S_IDLE: begin
                if (savePC_i) begin
                    if (!INA_i) begin
                        nmi_pend_d = 1'b0;
                        state_d    = S_NMI;
                    end else if (|w_enabled) begin
                        pending_d = pending_q & ~w_first_oh;
                        irq_id_d  = w_first_id;
                        state_d   = S_MI;
                    end else begin
                        spurious_d = 1'b1;
                    end
                end
            end
            S_MI, S_NMI: begin
                if (eoi_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // New edges are applied after the ack clear so a same-cycle set wins.
        pending_d  = pending_d | w_rise;
        nmi_pend_d = nmi_pend_d | w_nmi_rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            mask_q     <= '0;
            prev_irq_q <= '0;
            prev_nmi_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            irq_id_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            prev_irq_q <= irq_i;
            prev_nmi_q <= nmi_i;
            nmi_pend_q <= nmi_pend_d;
            irq_id_q   <= irq_id_d;
            spurious_q <= spurious_d;
        end
    end

    assign interrupt_o = |w_enabled;
    assign nmint_o     = nmi_pend_q;
    assign busy_o      = (state_q != S_IDLE);
    assign in_nmi_o    = (state_q == S_NMI);
    assign irq_id_o    = irq_id_q;
    assign spurious_o  = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Brief    : Directed vector table, reset corner sequence and randomized run
//            against a behavioural model of interrupt_controller.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq = '0;
    logic       nmi = 1'b0;
    logic       we = 1'b0;
    logic [3:0] wd = '0;
    logic       savePC = 1'b0;
    logic       INA = 1'b0;
    logic       eoi = 1'b0;
    logic       interrupt, nmint, busy, in_nmi, spurious;
    logic [1:0] irq_id;

    int errors = 0;
    int checks = 0;

    interrupt_controller #(.N_IRQ(4), .ID_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq),
        .nmi_i        (nmi),
        .mask_we_i    (we),
        .mask_wdata_i (wd),
        .savePC_i     (savePC),
        .INA_i        (INA),
        .eoi_i        (eoi),
        .interrupt_o  (interrupt),
        .nmint_o      (nmint),
        .busy_o       (busy),
        .irq_id_o     (irq_id),
        .in_nmi_o     (in_nmi),
        .spurious_o   (spurious)
    );

    always #5 clk = ~clk;

    // Output bundle order: {interrupt, nmint, busy, irq_id[1:0], in_nmi, spurious}
    function automatic logic [6:0] dut_out();
        return {interrupt, nmint, busy, irq_id, in_nmi, spurious};
    endfunction

    // Behavioural model: service mode 0 = none, 1 = maskable, 2 = NMI.
    logic [3:0] m_pend, m_mask, m_prev;
    logic       m_nmip, m_prev_nmi, m_spur;
    int         m_mode, m_id;

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0;
        m_nmip = 1'b0; m_prev_nmi = 1'b0; m_spur = 1'b0;
        m_mode = 0; m_id = 0;
    endtask

    task automatic model_update();
        logic [3:0] en, rise;
        logic       nrise;
        int         k;
        en    = m_pend & m_mask;
        rise  = irq & ~m_prev;
        nrise = nmi & ~m_prev_nmi;
        m_spur = 1'b0;
        if (m_mode == 0) begin
            if (savePC) begin
                if (!INA) begin
                    m_nmip = 1'b0;
                    m_mode = 2;
                end else if (en != 4'd0) begin
                    k = 0;
                    while (((en >> k) & 4'd1) == 4'd0) k++;
                    m_pend[k] = 1'b0;
                    m_id   = k;
                    m_mode = 1;
                end else begin
                    m_spur = 1'b1;
                end
            end
        end else if (eoi) begin
            m_mode = 0;
        end
        m_pend = m_pend | rise;
        m_nmip = m_nmip | nrise;
        if (we) m_mask = wd;
        m_prev = irq;
        m_prev_nmi = nmi;
    endtask

    function automatic logic [6:0] model_out();
        logic [1:0] id;
        id = m_id[1:0];
        return {(|(m_pend & m_mask)), m_nmip, (m_mode != 0), id, (m_mode == 2), m_spur};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {int,nmint,busy,id,in_nmi,spur}=%b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply(input logic [3:0] a_irq, input logic a_nmi, input logic a_we,
                         input logic [3:0] a_wd, input logic a_sp, input logic a_ina,
                         input logic a_eoi);
        @(negedge clk);
        irq = a_irq; nmi = a_nmi; we = a_we; wd = a_wd;
        savePC = a_sp; INA = a_ina; eoi = a_eoi;
        tick();
    endtask

    typedef struct {
        logic [3:0] irq;
        logic       nmi, we;
        logic [3:0] wd;
        logic       sp, ina, eoi;
        logic [6:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] a_irq, input logic a_nmi, input logic a_we,
                                input logic [3:0] a_wd, input logic a_sp, input logic a_ina,
                                input logic a_eoi, input logic [6:0] a_exp);
        vec_t v;
        v.irq = a_irq; v.nmi = a_nmi; v.we = a_we; v.wd = a_wd;
        v.sp = a_sp; v.ina = a_ina; v.eoi = a_eoi; v.exp = a_exp;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        //            irq    nmi we wd      sp ina eoi  {int,nmint,busy,id,in_nmi,spur}
        tbl.push_back(mk(4'h0, 0, 1, 4'hF, 0, 0, 0, 7'b0_0_0_00_0_0));
        tbl.push_back(mk(4'h4, 0, 0, 4'h0, 0, 0, 0, 7'b1_0_0_00_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 1, 1, 0, 7'b0_0_1_10_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 1, 7'b0_0_0_10_0_0));
        tbl.push_back(mk(4'hA, 0, 0, 4'h0, 0, 0, 0, 7'b1_0_0_10_0_0));
        tbl.push_back(mk(4'hA, 0, 0, 4'h0, 1, 1, 0, 7'b1_0_1_01_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 1, 7'b1_0_0_01_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 1, 1, 0, 7'b0_0_1_11_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 1, 7'b0_0_0_11_0_0));
        tbl.push_back(mk(4'h0, 0, 1, 4'h0, 0, 0, 0, 7'b0_0_0_11_0_0));
        tbl.push_back(mk(4'h1, 0, 0, 4'h0, 0, 0, 0, 7'b0_0_0_11_0_0));
        tbl.push_back(mk(4'h0, 0, 1, 4'h1, 0, 0, 0, 7'b1_0_0_11_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 1, 1, 0, 7'b0_0_1_00_0_0));
        tbl.push_back(mk(4'h0, 1, 0, 4'h0, 0, 0, 0, 7'b0_1_1_00_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 1, 0, 0, 7'b0_1_1_00_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 1, 7'b0_1_0_00_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 1, 0, 0, 7'b0_0_1_00_1_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 1, 7'b0_0_0_00_0_0));
        tbl.push_back(mk(4'h0, 0, 1, 4'h0, 0, 0, 0, 7'b0_0_0_00_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 1, 1, 0, 7'b0_0_0_00_0_1));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 0, 7'b0_0_0_00_0_0));
        tbl.push_back(mk(4'h1, 0, 1, 4'hF, 0, 0, 0, 7'b1_0_0_00_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 0, 7'b1_0_0_00_0_0));
        tbl.push_back(mk(4'h1, 0, 0, 4'h0, 1, 1, 0, 7'b1_0_1_00_0_0));
        tbl.push_back(mk(4'h1, 0, 0, 4'h0, 0, 0, 1, 7'b1_0_0_00_0_0));
        tbl.push_back(mk(4'h1, 0, 1, 4'h0, 1, 1, 0, 7'b0_0_1_00_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 1, 7'b0_0_0_00_0_0));
        tbl.push_back(mk(4'h0, 0, 1, 4'hF, 0, 0, 0, 7'b0_0_0_00_0_0));
        tbl.push_back(mk(4'h4, 0, 0, 4'h0, 0, 0, 0, 7'b1_0_0_00_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 1, 1, 1, 7'b0_0_1_10_0_0));
        tbl.push_back(mk(4'h0, 0, 0, 4'h0, 0, 0, 1, 7'b0_0_0_10_0_0));

        model_reset();
        #12;
        check("reset_state", dut_out(), 7'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].irq, tbl[i].nmi, tbl[i].we, tbl[i].wd,
                  tbl[i].sp, tbl[i].ina, tbl[i].eoi);
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // Enter NMI service with maskable lines 1 and 3 still pending.
        apply(4'hA, 1, 0, 4'h0, 0, 0, 0);
        check("pre_nmi", dut_out(), 7'b1_1_0_10_0_0);
        apply(4'hA, 0, 0, 4'h0, 1, 0, 0);
        check("in_nmi_pend_1010", dut_out(), 7'b1_0_1_10_1_0);

        // Asynchronous reset between clock edges, with lines held high through release.
        @(negedge clk);
        irq = 4'hF; nmi = 1'b1; we = 1'b1; wd = 4'hF;
        savePC = 1'b0; INA = 1'b0; eoi = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", dut_out(), 7'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("held_lines_after_reset", dut_out(), 7'b1_1_0_00_0_0);
        apply(4'hF, 1, 0, 4'h0, 1, 1, 0);
        check("ack_after_reset", dut_out(), 7'b1_1_1_00_0_0);

        // Randomized run against the model.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        irq = '0; nmi = 1'b0; we = 1'b0; savePC = 1'b0; eoi = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            logic [3:0] r_irq;
            logic       r_nmi;
            r_irq = irq ^ (4'($urandom) & 4'($urandom));
            r_nmi = nmi ^ ($urandom_range(7) == 0);
            apply(r_irq, r_nmi, ($urandom_range(7) == 0), 4'($urandom),
                  ($urandom_range(3) == 0), 1'($urandom_range(1)), ($urandom_range(3) == 0));
            check($sformatf("rand%0d", c), dut_out(), model_out());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
